// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial ripple adder, one result bit per clock
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin an addition; honoured only while idle
//   a, b   in   WIDTH-bit operands, captured with an accepted start
//   c      in   carry-in, captured with an accepted start
//   busy   out  high while an addition is running or completing
//   done   out  one-cycle pulse; s and co are valid in this cycle
//   s      out  WIDTH-bit sum, held until the next accepted start
//   co     out  carry-out, held until the next accepted start

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last_bit;
  logic             bit_sum;
  logic             bit_carry;

  assign accept    = (state_q == IDLE) && start;
  assign last_bit  = (cnt_q == CNT_W'(WIDTH - 1));

  // One full-adder slice working on the operand LSBs.
  assign bit_sum   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign bit_carry = (op_a_q[0] & op_b_q[0]) |
                     (op_a_q[0] & carry_q)   |
                     (op_b_q[0] & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath only moves on an accepted start or during ADD, so the result
  // and carry sit untouched through DONE and IDLE regardless of start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      op_a_q  <= a;
      op_b_q  <= b;
      sum_q   <= '0;
      carry_q <= c;
      cnt_q   <= '0;
    end else if (state_q == ADD) begin
      op_a_q  <= {1'b0, op_a_q[WIDTH-1:1]};
      op_b_q  <= {1'b0, op_b_q[WIDTH-1:1]};
      // LSB-first sum bits enter at the MSB; after WIDTH shifts bit 0 of the
      // sum has arrived at position 0.
      sum_q   <= {bit_sum, sum_q[WIDTH-1:1]};
      carry_q <= bit_carry;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign s    = sum_q;
  // After the last slice the carry flop holds the final carry-out.
  assign co   = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder

module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       c;
  logic       busy;
  logic       done;
  logic [7:0] s;
  logic       co;

  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       c4;
  logic       busy4;
  logic       done4;
  logic [3:0] s4;
  logic       co4;

  int n_checks;
  int n_fail;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co)
  );

  serial_adder #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .c     (c4),
    .busy  (busy4),
    .done  (done4),
    .s     (s4),
    .co    (co4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: waits for idle, launches one addition, waits for done.
  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output logic [7:0] rs, output logic rco, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy === 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    c     = tc;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rs  = s;
    rco = co;
  endtask

  task automatic test_reset;
    #12;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (s !== 8'h00) begin n_fail++; $display("FAIL reset_s: got %h expected 00", s); end
    n_checks++;
    if (co !== 1'b0) begin n_fail++; $display("FAIL reset_co: got %b expected 0", co); end
    n_checks++;
    if ({busy4, done4, co4, s4} !== 7'b0) begin
      n_fail++; $display("FAIL reset_w4: got %b expected 0000000", {busy4, done4, co4, s4});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 00", {busy, done}); end
  endtask

  // 0+0+0 with cycle-by-cycle busy/done profile.
  task automatic test_zero;
    @(negedge clk);
    start = 1'b1; a = 8'h00; b = 8'h00; c = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL zero_accept: got busy,done=%b expected 10", {busy, done}); end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1 || done !== (i == 8)) begin
        n_fail++; $display("FAIL zero_profile[%0d]: got busy,done=%b%b expected 1%b", i, busy, done, (i == 8));
      end
    end
    n_checks++;
    if ({co, s} !== 9'h000) begin n_fail++; $display("FAIL zero_result: got co,s=%h expected 000", {co, s}); end
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL zero_return_idle: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_vectors;
    logic [7:0]  va [3];
    logic [7:0]  vb [3];
    logic        vc [3];
    logic [8:0]  ve [3];
    logic [7:0]  rs;
    logic        rco;
    int          lat;
    va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; ve[0] = 9'h100;
    va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1'b1; ve[1] = 9'h1FF;
    va[2] = 8'h5A; vb[2] = 8'h25; vc[2] = 1'b1; ve[2] = 9'h080;
    for (int i = 0; i < 3; i++) begin
      do_add(va[i], vb[i], vc[i], rs, rco, lat);
      n_checks++;
      if (lat != 8) begin n_fail++; $display("FAIL vec%0d_latency: got %0d edges expected 8", i, lat); end
      n_checks++;
      if ({rco, rs} !== ve[i]) begin n_fail++; $display("FAIL vec%0d_result: got co,s=%h expected %h", i, {rco, rs}, ve[i]); end
    end
  endtask

  // Starts during ADD and DONE are ignored; result holds until a real start.
  task automatic test_ignored_start;
    int         ndone;
    logic [7:0] rs;
    logic       rco;
    int         lat;
    @(negedge clk);
    while (busy === 1'b1) @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; c = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        n_checks++;
        if (i != 8) begin n_fail++; $display("FAIL ign_done_time: got edge %0d expected 8", i); end
        n_checks++;
        if ({co, s} !== 9'h046) begin n_fail++; $display("FAIL ign_result: got co,s=%h expected 046", {co, s}); end
      end
      if (i == 2) begin start = 1'b1; a = 8'hFF; b = 8'hFF; c = 1'b1; end
      if (i == 3) start = 1'b0;
      if (i == 8) start = 1'b1;
      if (i == 9) begin
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_done_start: got busy %b expected 0", busy); end
      end
    end
    n_checks++;
    if (ndone != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d expected 1", ndone); end
    n_checks++;
    if ({co, s} !== 9'h046) begin n_fail++; $display("FAIL ign_hold: got co,s=%h expected 046", {co, s}); end
    do_add(8'h01, 8'h02, 1'b1, rs, rco, lat);
    n_checks++;
    if ({rco, rs} !== 9'h004 || lat != 8) begin
      n_fail++; $display("FAIL ign_next: got co,s=%h lat=%0d expected 004 lat=8", {rco, rs}, lat);
    end
  endtask

  task automatic test_reset_mid_add;
    @(negedge clk);
    while (busy === 1'b1) @(negedge clk);
    start = 1'b1; a = 8'h37; b = 8'h11; c = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, co, s} !== 11'h000) begin
      n_fail++; $display("FAIL mid_async_clear: got busy,done,co,s=%h expected 000", {busy, done, co, s});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, co, s} !== 11'h000) begin
      n_fail++; $display("FAIL mid_held_clear: got %h expected 000", {busy, done, co, s});
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; a = 8'h80; b = 8'h80; c = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL mid_first_start: got busy,done=%b expected 10", {busy, done}); end
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== (i == 8)) begin n_fail++; $display("FAIL mid_done[%0d]: got %b expected %b", i, done, (i == 8)); end
    end
    n_checks++;
    if ({co, s} !== 9'h100) begin n_fail++; $display("FAIL mid_result: got co,s=%h expected 100", {co, s}); end
  endtask

  // WIDTH=4 instance, start held high, every a/b/c combination.
  task automatic test_back_to_back;
    logic [4:0] exp_q [$];
    logic [4:0] e;
    logic       prev_busy;
    int         idx;
    int         cyc;
    int         last_done;
    int         ndone;
    logic [8:0] v;
    idx = 0; cyc = 0; last_done = -1; ndone = 0; prev_busy = 1'b0;
    @(negedge clk);
    v = 9'(idx);
    a4 = v[8:5]; b4 = v[4:1]; c4 = v[0];
    start4 = 1'b1;
    while (ndone < 512 && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy4 && !prev_busy) begin
        exp_q.push_back(5'(a4) + 5'(b4) + 5'(c4));
        idx++;
        if (idx < 512) begin
          v = 9'(idx);
          a4 = v[8:5]; b4 = v[4:1]; c4 = v[0];
        end else begin
          start4 = 1'b0;
        end
      end
      prev_busy = busy4;
      if (done4 === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_spurious_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          if ({co4, s4} !== e) begin
            n_fail++; $display("FAIL b2b_result[%0d]: got co,s=%h expected %h", ndone, {co4, s4}, e);
          end
        end
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done != 6) begin
            n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 6", ndone, cyc - last_done);
          end
        end
        last_done = cyc;
        ndone++;
      end
    end
    start4 = 1'b0;
    n_checks++;
    if (ndone != 512) begin n_fail++; $display("FAIL b2b_count: got %0d results expected 512", ndone); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n  = 1'b1;
    start  = 1'b0; a  = '0; b  = '0; c  = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
    test_reset();
    test_zero();
    test_vectors();
    test_ignored_start();
    test_reset_mid_add();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled on clk.
REQ-005 The block SHALL have port a  input  WIDTH  operand A, sampled with accepted start.
REQ-006 The block SHALL have port b  input  WIDTH  operand B, sampled with accepted start.
REQ-007 The block SHALL have port c  input  1  carry-in, sampled with accepted start.
REQ-008 The block SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; s and co are valid.
REQ-010 The block SHALL have port s  output  WIDTH  registered sum result.
REQ-011 The block SHALL have port co  output  1  registered carry-out result.

Function
REQ-012 The block SHALL implement states IDLE, ADD, DONE, encoded in a registered state machine.
REQ-013 In IDLE, start=1 at edge T SHALL be accepted: load a and b into operand shift registers, load c into the carry flop, clear the bit counter, go to ADD.
REQ-014 In ADD, each cycle SHALL form one full-adder bit from operand LSBs and the carry flop: bit sum = A0 xor B0 xor carry, carry next = majority(A0, B0, carry).
REQ-015 In ADD, each cycle SHALL right-shift both operand registers by one, shift the bit sum into the MSB of the result register, update the carry flop, increment the counter.
REQ-016 ADD SHALL last exactly WIDTH cycles; after the cycle with counter = WIDTH-1 the state SHALL go to DONE.
REQ-017 On entry to DONE, s SHALL equal (a + b + c) mod 2^WIDTH and co SHALL equal bit WIDTH of (a + b + c).
REQ-018 busy SHALL be 1 in ADD and DONE, 0 in IDLE; first high at T+1.
REQ-019 done SHALL be 1 for exactly one cycle, the DONE cycle, T+1+WIDTH; DONE SHALL then return to IDLE.
REQ-020 Total latency SHALL be WIDTH+1 cycles from the accepting edge to done high.
REQ-021 start SHALL be ignored in ADD and DONE; operands and carry-in changing during ADD SHALL not affect the result.
REQ-022 s and co SHALL hold their values from DONE until the next accepted start; they SHALL not be updated by ignored starts.
REQ-023 s and co SHALL be undefined-free but not meaningful during ADD; consumers SHALL sample only on done.
REQ-024 Back-to-back operation: start held high continuously SHALL be accepted in each IDLE cycle, giving one result per WIDTH+2 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, force state IDLE, busy 0, done 0, s 0, co 0, counter 0, carry flop 0, operand registers 0.
REQ-026 Reset asserted mid-ADD SHALL abandon the addition; no done pulse SHALL follow for it.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge where rst_n=1 and start=1.

Verification (WIDTH=8)
REQ-028 a=0x00, b=0x00, c=0, start at T -> done only at T+9, s=0x00, co=0, busy high T+1..T+9.
REQ-029 a=0xFF, b=0x01, c=0 -> s=0x00, co=1; a=0xFF, b=0xFF, c=1 -> s=0xFF, co=1; a=0x5A, b=0x25, c=1 -> s=0x80, co=0.
REQ-030 Start 0x12+0x34, then pulse start with a=0xFF, b=0xFF mid-ADD and at the DONE cycle -> single done, s=0x46, co=0, s/co held until the next IDLE start.
REQ-031 Drop rst_n at T+4 of an addition -> outputs 0 asynchronously, no done; after release, 0x80+0x80+0 -> s=0x00, co=1.
REQ-032 Exhaustive WIDTH=4 sweep of all a, b, c (512 cases) with start held high -> every result matches a+b+c, done spacing exactly 6 cycles.
